// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents:
//   loader_state_t  - loader FSM states (IDLE, LEN_HI, LEN_LO, DATA, DONE)
//   BYTES_PER_WORD  - stream bytes packed into one memory word
//   WORD_WIDTH      - instruction word width
//   BYTE_WIDTH      - stream byte width
//   WORD_ADDR_SHIFT - word index to byte address shift
//   word_byte_addr  - byte address of word number word_idx above base
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_WIDTH      = 32;
  localparam int BYTE_WIDTH      = 8;
  localparam int WORD_ADDR_SHIFT = 2;

  function automatic logic [WORD_WIDTH-1:0] word_byte_addr(
    input logic [WORD_WIDTH-1:0] base,
    input logic [WORD_WIDTH-1:0] word_idx
  );
    return base + (word_idx << WORD_ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects stream bytes big-endian into 32-bit words.
// Ports:
//   clock        in   system clock
//   Reset        in   asynchronous active-low reset
//   i_clear      in   restart the byte index at 0 (new load)
//   i_byte_valid in   a byte is accepted this cycle
//   i_byte       in   accepted byte
//   o_last_byte  out  combinational: the byte accepted now completes a word
//   o_word_valid out  one-cycle pulse the cycle after a word completes
//   o_word       out  last completed word (held between pulses)
module byte_packer
  import mips_pkg::*;
(
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  i_clear,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_last_byte,
  output logic                  o_word_valid,
  output logic [WORD_WIDTH-1:0] o_word
);

  // Only the first three bytes need holding; the fourth arrives with the write.
  logic [WORD_WIDTH-BYTE_WIDTH-1:0] r_shift;
  logic [1:0]                       r_idx;
  logic                             r_word_valid;
  logic [WORD_WIDTH-1:0]            r_word;

  assign o_last_byte  = i_byte_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_byte_valid) begin
        r_shift <= {r_shift[WORD_WIDTH-2*BYTE_WIDTH-1:0], i_byte};
        r_idx   <= r_idx + 2'd1;
        if (o_last_byte) begin
          r_word       <= {r_shift, i_byte};
          r_word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a byte-streamed program image into instruction memory
// and holds the core until a clean load has completed.
// Stream: 16-bit word count N (high byte first), then 4*N bytes, big-endian.
// Ports:
//   clock, Reset           clock, asynchronous active-low reset
//   start                  pulse; begins a load from IDLE or DONE
//   rx_valid/rx_data       byte stream in; rx_ready out
//   mem_we/mem_addr/mem_wdata  one-cycle word write to instruction memory
//   cpu_hold               1 = core must not advance its PC
//   load_done/load_error   load finished / header count exceeded depth
//   words_loaded           words written in the current or last load
module imem_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  loader_state_t r_state;
  loader_state_t w_state_next;

  logic [BYTE_WIDTH-1:0] r_len_hi;
  logic [15:0]           r_count;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic                  r_load_error;
  logic [WORD_WIDTH-1:0] r_mem_addr;

  logic        w_rx_ready;
  logic        w_start_load;
  logic [15:0] w_len;
  logic        w_len_too_big;
  logic        w_pack_valid;
  logic        w_last_byte;
  logic        w_word_valid;
  logic [WORD_WIDTH-1:0] w_word;
  logic        w_word_final;

  assign w_len         = {r_len_hi, rx_data};
  assign w_len_too_big = (33'(w_len) > DEPTH);
  assign w_pack_valid  = (r_state == DATA) && rx_valid;
  // True while the word being completed is the last one of the header count.
  assign w_word_final  = ((32'(r_words_loaded) + 32'd1) == 32'(r_count));

  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    w_start_load = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = LEN_HI;
          w_start_load = 1'b1;
        end
      end
      LEN_HI: begin
        w_rx_ready = 1'b1;
        if (rx_valid) w_state_next = LEN_LO;
      end
      LEN_LO: begin
        w_rx_ready = 1'b1;
        if (rx_valid) begin
          if (w_len == 16'd0 || w_len_too_big) w_state_next = DONE;
          else                                 w_state_next = DATA;
        end
      end
      DATA: begin
        // Never back-pressures: a write register is free every cycle.
        w_rx_ready = 1'b1;
        if (w_last_byte && w_word_final) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_len_hi       <= '0;
      r_count        <= '0;
      r_words_loaded <= '0;
      r_load_error   <= 1'b0;
      r_mem_addr     <= BASE_ADDR;
    end else begin
      if (w_start_load) begin
        r_words_loaded <= '0;
        r_load_error   <= 1'b0;
      end
      if (r_state == LEN_HI && rx_valid) r_len_hi <= rx_data;
      if (r_state == LEN_LO && rx_valid) begin
        r_count <= w_len;
        if (w_len_too_big) r_load_error <= 1'b1;
      end
      // Address uses the count before this word is added.
      if (w_last_byte) begin
        r_mem_addr     <= word_byte_addr(BASE_ADDR, 32'(r_words_loaded));
        r_words_loaded <= r_words_loaded + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  byte_packer u_packer (
    .clock        (clock),
    .Reset        (Reset),
    .i_clear      (w_start_load),
    .i_byte_valid (w_pack_valid),
    .i_byte       (rx_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign rx_ready     = w_rx_ready;
  assign mem_we       = w_word_valid;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = w_word;
  assign load_done    = (r_state == DONE);
  assign load_error   = r_load_error;
  // The core is released only from a DONE reached without error.
  assign cpu_hold     = !((r_state == DONE) && !r_load_error);
  assign words_loaded = r_words_loaded;

endmodule
